// File: rtl/kp_pkg.sv
// Shared types and defaults for the kernel line scheduler: FSM state encoding,
// parameter defaults and the counter-width helper.
package kp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_REQ  = 3'd1,
        ST_BURST     = 3'd2,
        ST_GUARD     = 3'd3,
        ST_PAD_WAIT  = 3'd4,
        ST_PAD       = 3'd5,
        ST_PAD_GUARD = 3'd6,
        ST_DONE      = 3'd7
    } kp_state_e;

    localparam int DEF_LINE_LENGTH = 640;
    localparam int DEF_LINE_COUNT  = 480;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_PAD_LINES   = 1;
    localparam int DEF_PAD_VALUE   = 0;
    localparam int DEF_GUARD_CYC   = 2;

    // One spare bit so a counter can hold its terminal value without wrapping.
    function automatic int ctr_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/kp_burst_counter.sv
// Per-line issue/return pixel counters; both saturate at LINE_LENGTH and
// clear together at the start of every real or pad line.
module kp_burst_counter
    import kp_pkg::*;
#(
    parameter int LINE_LENGTH = DEF_LINE_LENGTH,
    parameter int CW          = ctr_width(DEF_LINE_LENGTH)
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_issue,
    input  logic i_ret,
    output logic o_issue_done,
    output logic o_ret_last
);

    localparam logic [CW-1:0] LEN    = CW'(LINE_LENGTH);
    localparam logic [CW-1:0] LEN_M1 = CW'(LINE_LENGTH - 1);

    // Index 0 counts FIFO pops issued, index 1 counts pixels returned to the kernel.
    logic [1:0]    step;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    assign step = {i_ret, i_issue};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (i_clr) begin
                    cnt_d[gi] = '0;
                end else if (step[gi] && (cnt_q[gi] != LEN)) begin
                    cnt_d[gi] = cnt_q[gi] + CW'(1);
                end
            end

            always_ff @(posedge i_clk) begin
                if (!i_rstn) begin
                    cnt_q[gi] <= '0;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end
        end
    endgenerate

    assign o_issue_done = (cnt_q[0] == LEN);
    assign o_ret_last   = (cnt_q[1] == LEN_M1);

endmodule

// File: rtl/kp_line_scheduler.sv
// Feeds one frame from the pixel FIFO to kernel control a full line per request,
// then appends constant-valued border lines and signals frame completion.
module kp_line_scheduler
    import kp_pkg::*;
#(
    parameter int LINE_LENGTH = DEF_LINE_LENGTH,
    parameter int LINE_COUNT  = DEF_LINE_COUNT,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PAD_LINES   = DEF_PAD_LINES,
    parameter int PAD_VALUE   = DEF_PAD_VALUE,
    parameter int GUARD_CYC   = DEF_GUARD_CYC,
    localparam int LW         = ctr_width(LINE_COUNT + PAD_LINES)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
    output logic                  o_fifo_rd,
    input  logic                  i_req,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic [LW-1:0]         o_line_idx,
    output logic                  o_frame_done,
    output logic                  o_start_err
);

    localparam int CW = ctr_width(LINE_LENGTH);
    localparam int GW = ctr_width(GUARD_CYC + 1);
    localparam logic [LW-1:0]         REAL_LINES = LW'(LINE_COUNT);
    localparam logic [LW-1:0]         ALL_LINES  = LW'(LINE_COUNT + PAD_LINES);
    localparam logic [GW-1:0]         GUARD_LAST = GW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [DATA_WIDTH-1:0] PAD_WORD   = DATA_WIDTH'(PAD_VALUE);

    kp_state_e       state_q, state_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic [LW-1:0]   line_idx_q, line_idx_d;
    logic            frame_done_q, frame_done_d;
    logic            start_err_q, start_err_d;
    logic [GW-1:0]   guard_q, guard_d;

    logic            fifo_rd;
    logic            cnt_clr;
    logic            issue_done;
    logic            ret_last;
    logic [LW-1:0]   line_idx_inc;
    kp_state_e       after_guard;

    kp_burst_counter #(
        .LINE_LENGTH (LINE_LENGTH),
        .CW          (CW)
    ) u_burst_counter (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_clr        (cnt_clr),
        .i_issue      (fifo_rd),
        .i_ret        (valid_q),
        .o_issue_done (issue_done),
        .o_ret_last   (ret_last)
    );

    assign line_idx_inc = (line_idx_q < ALL_LINES) ? line_idx_q + LW'(1) : line_idx_q;

    // Pad lines share the guard path; PAD_LINES=0 makes ALL_LINES==REAL_LINES and skips padding.
    assign after_guard = (line_idx_q >= ALL_LINES)  ? ST_DONE :
                         (line_idx_q >= REAL_LINES) ? ST_PAD_WAIT : ST_WAIT_REQ;

    always_comb begin
        state_d      = state_q;
        valid_d      = 1'b0;
        line_idx_d   = line_idx_q;
        frame_done_d = 1'b0;
        start_err_d  = 1'b0;
        guard_d      = guard_q;
        fifo_rd      = 1'b0;
        cnt_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_WAIT_REQ;
                    line_idx_d = '0;
                end
            end
            ST_WAIT_REQ, ST_PAD_WAIT: begin
                cnt_clr = 1'b1;
                if (i_req) begin
                    state_d = (state_q == ST_WAIT_REQ) ? ST_BURST : ST_PAD;
                    valid_d = (state_q == ST_PAD_WAIT);
                end
            end
            ST_BURST: begin
                fifo_rd = i_rstn && !i_fifo_empty && !issue_done;
                valid_d = fifo_rd;
                if (valid_q && ret_last) begin
                    state_d    = ST_GUARD;
                    guard_d    = '0;
                    line_idx_d = line_idx_inc;
                end
            end
            ST_PAD: begin
                if (ret_last) begin
                    state_d    = ST_PAD_GUARD;
                    guard_d    = '0;
                    line_idx_d = line_idx_inc;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_GUARD, ST_PAD_GUARD: begin
                if (guard_q >= GUARD_LAST) begin
                    state_d      = after_guard;
                    frame_done_d = (after_guard == ST_DONE);
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over a simultaneous start; no pop is issued in the abort cycle.
        if (state_q != ST_IDLE) begin
            if (i_abort) begin
                state_d      = ST_IDLE;
                valid_d      = 1'b0;
                fifo_rd      = 1'b0;
                frame_done_d = 1'b0;
            end else if (i_start) begin
                start_err_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            line_idx_q   <= '0;
            frame_done_q <= 1'b0;
            start_err_q  <= 1'b0;
            guard_q      <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            line_idx_q   <= line_idx_d;
            frame_done_q <= frame_done_d;
            start_err_q  <= start_err_d;
            guard_q      <= guard_d;
        end
    end

    // FIFO data arrives one cycle after the pop, aligned with the registered strobe.
    assign o_data       = !valid_q ? '0 : ((state_q == ST_PAD) ? PAD_WORD : i_fifo_rdata);
    assign o_fifo_rd    = fifo_rd;
    assign o_valid      = valid_q;
    assign o_busy       = busy_q;
    assign o_line_idx   = line_idx_q;
    assign o_frame_done = frame_done_q;
    assign o_start_err  = start_err_q;

endmodule

// File: tb/tb_kp_line_scheduler.sv
// Directed bench for kp_line_scheduler: FIFO model feeding a scoreboard of
// expected pixels, per-line/guard monitors, and a linear sequence of scenarios.
module tb_kp_line_scheduler;

    localparam int LEN   = 8;
    localparam int COUNT = 4;
    localparam int PADL  = 1;
    localparam int PADV  = 0;
    localparam int GUARD = 2;
    localparam int TOTAL = LEN * (COUNT + PADL);

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       fifo_empty = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       req = 1'b0;
    logic       fifo_rd;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic [3:0] line_idx;
    logic       frame_done;
    logic       start_err;

    int checks = 0;
    int errors = 0;

    kp_line_scheduler #(
        .LINE_LENGTH (LEN),
        .LINE_COUNT  (COUNT),
        .DATA_WIDTH  (8),
        .PAD_LINES   (PADL),
        .PAD_VALUE   (PADV),
        .GUARD_CYC   (GUARD)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_abort      (abort),
        .i_fifo_empty (fifo_empty),
        .i_fifo_rdata (rdata),
        .o_fifo_rd    (fifo_rd),
        .i_req        (req),
        .o_data       (data),
        .o_valid      (valid),
        .o_busy       (busy),
        .o_line_idx   (line_idx),
        .o_frame_done (frame_done),
        .o_start_err  (start_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // FIFO model: every pop yields the next ramp value and queues it as expected output.
    logic [7:0] next_pix = 8'h10;
    logic [7:0] exp_q[$];
    int         rd_count = 0;

    always @(posedge clk) begin
        if (fifo_rd) begin
            rdata    <= next_pix;
            exp_q.push_back(next_pix);
            next_pix <= next_pix + 8'd1;
            rd_count++;
        end
    end

    // Output monitor, sampled on the falling edge.
    int         cyc = 0;
    int         frame_valids = 0;
    int         line_valids = 0;
    int         done_cnt = 0;
    int         last_valid_cyc = 0;
    int         end_cyc = 0;
    bit         gap_pending = 0;
    int         min_gap = 1000;
    int         max_gap = -1;
    int         max_in_gap = 0;
    logic [3:0] prev_idx = 4'd0;
    int         line_lens[$];

    always @(negedge clk) begin
        int expv;
        int g;
        cyc++;
        if (fifo_rd) chk("rd_while_empty", fifo_empty, 0);
        if (frame_done) done_cnt++;
        if (gap_pending && (fifo_rd || valid)) begin
            g = cyc - end_cyc;
            if (g < min_gap) min_gap = g;
            if (g > max_gap) max_gap = g;
            gap_pending = 0;
        end
        if (valid) begin
            chk("valid_outside_busy", busy, 1);
            if (line_valids > 0 && (cyc - last_valid_cyc - 1) > max_in_gap)
                max_in_gap = cyc - last_valid_cyc - 1;
            last_valid_cyc = cyc;
            line_valids++;
            frame_valids++;
            if (frame_valids <= LEN * COUNT) begin
                expv = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 32'hFFFF;
                chk("pixel", data, expv);
            end else begin
                chk("pad_pixel", data, PADV);
            end
            if (line_valids == LEN) begin
                gap_pending = 1;
                end_cyc     = cyc;
            end
        end
        if (line_idx != prev_idx) begin
            if (line_idx == prev_idx + 4'd1) begin
                line_lens.push_back(line_valids);
                line_valids = 0;
            end
            prev_idx = line_idx;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        frame_valids = 0;
        line_valids  = 0;
        gap_pending  = 0;
        min_gap      = 1000;
        max_gap      = -1;
        max_in_gap   = 0;
        prev_idx     = line_idx;
        line_lens.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_valids(input int n, input int budget);
        int k = 0;
        while (frame_valids < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("valid_count_timeout", frame_valids >= n, 1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && k < budget) begin
            tick(1);
            k++;
        end
        chk("frame_done_seen", done_cnt - d0, 1);
        chk("frame_done_width", frame_done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic check_frame(input int exp_in_gap);
        chk("frame_valids", frame_valids, TOTAL);
        chk("lines_sent", line_lens.size(), COUNT + PADL);
        for (int i = 0; i < line_lens.size(); i++) chk("line_length", line_lens[i], LEN);
        chk("guard_gap_min", min_gap, GUARD + 2);
        chk("guard_gap_max", max_gap, GUARD + 2);
        chk("in_line_gap", max_in_gap, exp_in_gap);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_line_idx", line_idx, COUNT + PADL);
    endtask

    initial begin
        int d0;
        int r0;

        // Reset state
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_line_idx", line_idx, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_start_err", start_err, 0);
        chk("rst_data", data, 0);
        rstn = 1'b1;
        req  = 1'b1;
        tick(2);

        // 1: full frame, FIFO always full, kernel always requesting (also covers guard timing)
        clear_mon();
        pulse_start();
        chk("busy_after_start", busy, 1);
        wait_done(500);
        check_frame(0);

        // 2: FIFO empty for 3 cycles mid-burst
        clear_mon();
        pulse_start();
        wait_valids(3, 100);
        fifo_empty = 1'b1;
        tick(3);
        fifo_empty = 1'b0;
        wait_done(500);
        check_frame(3);

        // 4: abort at pixel 5 of line 2, then restart
        clear_mon();
        pulse_start();
        wait_valids(2 * LEN + 5, 300);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_fifo_rd", fifo_rd, 0);
        chk("abort_line_idx", line_idx, 2);
        d0 = done_cnt;
        tick(20);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_valids", frame_valids, 2 * LEN + 6);
        exp_q.delete();
        clear_mon();
        pulse_start();
        chk("restart_line_idx", line_idx, 0);
        chk("restart_busy", busy, 1);
        wait_done(500);
        check_frame(0);

        // 5: start while busy
        clear_mon();
        pulse_start();
        wait_valids(10, 200);
        pulse_start();
        chk("start_err_pulse", start_err, 1);
        tick(1);
        chk("start_err_clear", start_err, 0);
        chk("start_err_busy", busy, 1);
        wait_done(500);
        check_frame(0);

        // 6: reset for one cycle during the pad line
        clear_mon();
        pulse_start();
        wait_valids(LEN * COUNT + 3, 500);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_fifo_rd", fifo_rd, 0);
        chk("mid_rst_line_idx", line_idx, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        r0 = rd_count;
        d0 = done_cnt;
        tick(15);
        chk("post_rst_no_pop", rd_count, r0);
        chk("post_rst_no_done", done_cnt, d0);
        chk("post_rst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
